// File: rtl/mult_stim_driver.sv
// Initiator/checker for the multiplier handshake wrapper: issues NTESTS operand pairs and scores each product.
// Build macro MULT_STIM_SIGNED_EN switches operands and expected value to two's complement.
//
// state | meaning
// IDLE  | after reset, waiting for start
// SEND  | operands presented, in_valid_o high until the wrapper takes them
// RECV  | out_ready_o high, waiting for the product; watchdog running
// DONE  | run finished or aborted; done held until next start
module mult_stim_driver #(
    parameter int NBIT    = 8,
    parameter int NTESTS  = 16,
    parameter int A_START = 3,
    parameter int A_STEP  = 1,
    parameter int B_START = 5,
    parameter int B_STEP  = 0,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [NBIT-1:0]   a_o,
    output logic [NBIT-1:0]   b_o,
    output logic              in_valid_o,
    input  logic              in_ready_i,
    input  logic [2*NBIT-1:0] y_i,
    input  logic              out_valid_i,
    output logic              out_ready_o,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [15:0]       pass_cnt,
    output logic [15:0]       err_cnt
);
    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    localparam logic [NBIT-1:0] A0      = NBIT'(A_START);
    localparam logic [NBIT-1:0] A_INC   = NBIT'(A_STEP);
    localparam logic [NBIT-1:0] B0      = NBIT'(B_START);
    localparam logic [NBIT-1:0] B_DEC   = NBIT'(B_STEP);
    localparam logic [15:0]     K_LAST  = 16'(NTESTS - 1);
    localparam logic [15:0]     WD_LAST = 16'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [15:0]       k;
    logic [15:0]       wdog;
    logic [2*NBIT-1:0] expected;
    logic [2*NBIT-1:0] product;
    logic              start_ok;
    logic              in_xfer;
    logic              out_xfer;
    logic              last;

`ifdef MULT_STIM_SIGNED_EN
    logic signed [2*NBIT-1:0] a_ext, b_ext, p_signed;
    assign a_ext    = {{NBIT{a_o[NBIT-1]}}, a_o};
    assign b_ext    = {{NBIT{b_o[NBIT-1]}}, b_o};
    assign p_signed = a_ext * b_ext;
    assign product  = p_signed;
`else
    assign product = {{NBIT{1'b0}}, a_o} * {{NBIT{1'b0}}, b_o};
`endif

    assign start_ok    = start && ((state == IDLE) || (state == DONE));
    assign in_xfer     = (state == SEND) && in_ready_i;
    assign out_xfer    = (state == RECV) && out_valid_i;
    assign last        = (k == K_LAST);

    assign in_valid_o  = (state == SEND);
    assign out_ready_o = (state == RECV);
    assign busy        = (state == SEND) || (state == RECV);
    assign done        = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = SEND;
            SEND:       if (in_ready_i) state_nxt = RECV;
            RECV: begin
                if (out_valid_i)          state_nxt = last ? DONE : SEND;
                else if (wdog == WD_LAST) state_nxt = DONE;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k        <= '0;
            wdog     <= '0;
            a_o      <= '0;
            b_o      <= '0;
            expected <= '0;
            pass_cnt <= '0;
            err_cnt  <= '0;
            timeout  <= 1'b0;
        end else begin
            if (start_ok) begin
                k        <= '0;
                a_o      <= A0;
                b_o      <= B0;
                pass_cnt <= '0;
                err_cnt  <= '0;
                timeout  <= 1'b0;
            end
            if (in_xfer) begin
                expected <= product;
                wdog     <= '0;
            end
            // Operands advance incrementally; wrap modulo 2^NBIT falls out of the adder width.
            if (out_xfer) begin
                if (y_i == expected) begin
                    if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
                end else if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
                if (!last) begin
                    k   <= k + 16'd1;
                    a_o <= a_o + A_INC;
                    b_o <= b_o - B_DEC;
                end
            end else if (state == RECV) begin
                if (wdog == WD_LAST) timeout <= 1'b1;
                else                 wdog    <= wdog + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mult_stim_driver.sv
// Bench for mult_stim_driver: the bench plays the multiplier wrapper and predicts operands/products from closed-form sequences.
module tb_mult_stim_driver;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, in_ready_i, out_valid_i;
    logic [15:0] y_i;
    logic [7:0]  a_o, b_o;
    logic        in_valid_o, out_ready_o, busy, done, timeout;
    logic [15:0] pass_cnt, err_cnt;

    logic        start2, in_ready2, out_valid2;
    logic [15:0] y2;
    logic [7:0]  a2, b2;
    logic        in_valid2, out_ready2, busy2, done2, timeout2;
    logic [15:0] pass2, err2;

    int n_assert = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;

    mult_stim_driver dut (
        .clk(clk), .rst(rst), .start(start),
        .a_o(a_o), .b_o(b_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
        .y_i(y_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
        .busy(busy), .done(done), .timeout(timeout),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt)
    );

    mult_stim_driver #(.A_START(255), .A_STEP(1), .B_START(255), .B_STEP(0), .NTESTS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .a_o(a2), .b_o(b2), .in_valid_o(in_valid2), .in_ready_i(in_ready2),
        .y_i(y2), .out_valid_i(out_valid2), .out_ready_o(out_ready2),
        .busy(busy2), .done(done2), .timeout(timeout2),
        .pass_cnt(pass2), .err_cnt(err2)
    );

    always @(posedge clk) if (in_valid_o && in_ready_i) xfer_cnt <= xfer_cnt + 1;

    function automatic int ref_a(input int k, input int s, input int st);
        return (((s + k * st) % 256) + 256) % 256;
    endfunction

    function automatic int ref_b(input int k, input int s, input int st);
        return (((s - k * st) % 256) + 256) % 256;
    endfunction

    function automatic logic [15:0] ref_y(input int a, input int b);
        int sa, sb;
`ifdef MULT_STIM_SIGNED_EN
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
`else
        sa = a;
        sb = b;
`endif
        return 16'(sa * sb);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One wrapper-side transaction, entered at the negedge where SEND is expected.
    task automatic do_txn(input int k, input int rdy_dly, input int y_dly,
                          input bit corrupt, input bit glitch, input bit dual);
        int a, b;
        logic [15:0] y;
        a = ref_a(k, 3, 1);
        b = ref_b(k, 5, 0);
        y = ref_y(a, b);
        check("send_valid", in_valid_o, 1);
        check("a_o", a_o, a);
        check("b_o", b_o, b);
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            check("send_hold", {in_valid_o, a_o, b_o}, {1'b1, 8'(a), 8'(b)});
        end
        in_ready_i = 1'b1;
        if (dual) begin
            out_valid_i = 1'b1;
            y_i = y ^ 16'h5555;
        end
        @(negedge clk);
        in_ready_i  = 1'b0;
        out_valid_i = 1'b0;
        check("recv_state", {in_valid_o, out_ready_o, busy}, 3'b011);
        if (glitch) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("busy_start_ignored", {out_ready_o, busy, done}, 3'b110);
        end
        repeat (y_dly) @(negedge clk);
        y_i = corrupt ? (y ^ 16'h0001) : y;
        out_valid_i = 1'b1;
        @(negedge clk);
        out_valid_i = 1'b0;
    endtask

    task automatic run(input int corrupt_k, input bit rnd, input int fixed_rdy,
                       input int glitch_k, input int dual_k);
        int ep, ee, x0, rd, yd;
        bit c;
        ep = 0;
        ee = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_flags", {busy, done, timeout}, 3'b100);
        check("start_pass", pass_cnt, 0);
        check("start_err", err_cnt, 0);
        x0 = xfer_cnt;
        for (int k = 0; k < 16; k++) begin
            rd = rnd ? int'($urandom_range(0, 3)) : fixed_rdy;
            yd = rnd ? int'($urandom_range(0, 4)) : 0;
            c  = (k == corrupt_k) || (rnd && ($urandom_range(0, 3) == 0));
            do_txn(k, rd, yd, c, k == glitch_k, k == dual_k);
            if (c) ee++;
            else   ep++;
            check("pass_cnt", pass_cnt, ep);
            check("err_cnt", err_cnt, ee);
            check("done_flag", done, (k == 15));
        end
        check("end_flags", {busy, timeout, in_valid_o, out_ready_o}, 4'b0000);
        check("input_xfers", xfer_cnt - x0, 16);
    endtask

    initial begin
        int a, b;
        rst = 1'b0; start = 1'b0; in_ready_i = 1'b0; out_valid_i = 1'b0; y_i = '0;
        start2 = 1'b0; in_ready2 = 1'b0; out_valid2 = 1'b0; y2 = '0;
        repeat (3) @(negedge clk);
        check("reset_outs", {a_o, b_o, in_valid_o, out_ready_o, busy, done, timeout}, 0);
        check("reset_cnts", {pass_cnt, err_cnt}, 0);
        rst = 1'b1;
        @(negedge clk);

        out_valid_i = 1'b1;
        y_i = 16'd15;
        repeat (2) @(negedge clk);
        out_valid_i = 1'b0;
        check("idle_ignore", {busy, done, out_ready_o, pass_cnt}, 0);

        run(-1, 1'b0, 0, -1, -1);
        run(4, 1'b0, 1, -1, -1);
        run(-1, 1'b0, 5, 9, 3);
        repeat (3) run(-1, 1'b1, 0, -1, -1);

        // watchdog: product never arrives
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("wd_a", {a_o, b_o}, {8'd3, 8'd5});
        in_ready_i = 1'b1;
        @(negedge clk);
        in_ready_i = 1'b0;
        repeat (63) @(negedge clk);
        check("wd_early", {done, timeout, busy}, 3'b001);
        @(negedge clk);
        check("wd_fire", {done, timeout, busy}, 3'b110);
        check("wd_cnts", {pass_cnt, err_cnt}, 0);
        out_valid_i = 1'b1;
        y_i = 16'd15;
        @(negedge clk);
        out_valid_i = 1'b0;
        check("wd_late_y", {done, timeout, pass_cnt, err_cnt}, {2'b11, 32'd0});
        run(-1, 1'b0, 0, -1, -1);

        // reset in the middle of transaction 7
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 7; k++) do_txn(k, 0, 0, 1'b0, 1'b0, 1'b0);
        check("mid_a", a_o, ref_a(7, 3, 1));
        check("mid_pass", pass_cnt, 7);
        rst = 1'b0;
        #1;
        check("midrst_outs", {a_o, b_o, in_valid_o, out_ready_o, busy, done, timeout}, 0);
        check("midrst_cnts", {pass_cnt, err_cnt}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run(-1, 1'b1, 0, -1, -1);

        // operand wrap on the second instance
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            a = ref_a(k, 255, 1);
            b = ref_b(k, 255, 0);
            check("wrap_a", a2, a);
            check("wrap_b", b2, b);
            in_ready2 = 1'b1;
            @(negedge clk);
            in_ready2 = 1'b0;
            y2 = ref_y(a, b);
            out_valid2 = 1'b1;
            @(negedge clk);
            out_valid2 = 1'b0;
        end
        check("wrap_pass", pass2, 2);
        check("wrap_err", err2, 0);
        check("wrap_flags", {done2, busy2, timeout2, in_valid2, out_ready2}, 5'b10000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
